// File: rtl/pipeline_pkg.sv
// Shared constants for the pipeline stall controller: state encoding and the
// opcode patterns the controller decodes from the fetched instruction word.
package pipeline_pkg;

    localparam logic [1:0] ST_RUN_ENC  = 2'd0;
    localparam logic [1:0] ST_WAIT_ENC = 2'd1;
    localparam logic [1:0] ST_HALT_ENC = 2'd2;
    localparam logic [1:0] ST_REL_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN  = ST_RUN_ENC,
        ST_WAIT = ST_WAIT_ENC,
        ST_HALT = ST_HALT_ENC,
        ST_REL  = ST_REL_ENC
    } state_e;

    localparam logic [4:0] OP_LOAD    = 5'b10100;
    localparam logic [4:0] OP_HALT    = 5'b10001;
    localparam logic [2:0] JMP_PREFIX = 3'b111;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between program memory / IF-ID register and the stall controller.
interface hazard_stall_ctrl_if
    import pipeline_pkg::*;
#(
    parameter int IW  = 20,
    parameter int PCW = 16
);
    // No valid/ready here: every signal is meaningful on every cycle; the
    // controller samples its inputs and the consumer samples its outputs at
    // each rising clk edge.
    logic [IW-1:0]  ins_pm;
    logic           ext_stall;
    logic           resume;
    logic           stall;
    logic           stall_pm;
    logic           flush;
    logic           halted;
    logic [PCW-1:0] stall_cycles;
    state_e         dbg_state;

    modport master (
        output ins_pm, ext_stall, resume,
        input  stall, stall_pm, flush, halted, stall_cycles, dbg_state
    );

    modport slave (
        input  ins_pm, ext_stall, resume,
        output stall, stall_pm, flush, halted, stall_cycles, dbg_state
    );

endinterface

// File: rtl/stall_perf_counter.sv
// Saturating event counter with synchronous clear; counts stall cycles.
module stall_perf_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall controller: decodes halt/jump/load from the fetched word and
// produces PC-hold stall, its registered copy, and jump bubble flush.
module hazard_stall_ctrl
    import pipeline_pkg::*;
#(
    parameter int             IW         = 20,
    parameter int             OPW        = 5,
    parameter logic [OPW-1:0] OP_LOAD    = pipeline_pkg::OP_LOAD,
    parameter logic [OPW-1:0] OP_HALT    = pipeline_pkg::OP_HALT,
    parameter int             JPW        = 3,
    parameter logic [JPW-1:0] JMP_PREFIX = pipeline_pkg::JMP_PREFIX,
    parameter int             LD_STALL   = 1,
    parameter int             JMP_STALL  = 2,
    parameter int             PCW        = 16
) (
    input logic               clk,
    input logic               reset,
    hazard_stall_ctrl_if.slave bus
);

    localparam int NMAX = (LD_STALL > JMP_STALL) ? LD_STALL : JMP_STALL;
    localparam int CW   = $clog2(NMAX + 1);
    localparam logic [CW-1:0] LD_RELOAD  = CW'(LD_STALL - 1);
    localparam logic [CW-1:0] JMP_RELOAD = CW'(JMP_STALL - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_jmp_q, is_jmp_d;
    logic          stall_pm_q;
    logic          halted_q;
    logic          stall_c;
    logic          flush_c;

    logic [OPW-1:0] opcode;
    logic [JPW-1:0] jprefix;
    logic           dec_halt;
    logic           dec_jmp;
    logic           dec_load;
    logic           unused_ins_low;

    assign opcode   = bus.ins_pm[IW-1 -: OPW];
    assign jprefix  = bus.ins_pm[IW-1 -: JPW];
    assign dec_halt = (opcode == OP_HALT);
    assign dec_jmp  = (jprefix == JMP_PREFIX);
    assign dec_load = (opcode == OP_LOAD);
    assign unused_ins_low = ^bus.ins_pm[IW-OPW-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_jmp_d = is_jmp_q;
        stall_c  = 1'b0;
        flush_c  = 1'b0;
        if (reset) begin
            stall_c = 1'b0;
        end else if (bus.ext_stall) begin
            // Freeze: everything holds, no decode, bubble suppressed.
            stall_c = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (dec_halt) begin
                        stall_c = 1'b1;
                        state_d = ST_HALT;
                    end else if (dec_jmp || dec_load) begin
                        stall_c  = 1'b1;
                        flush_c  = dec_jmp;
                        is_jmp_d = dec_jmp;
                        if (dec_jmp ? (JMP_STALL == 1) : (LD_STALL == 1)) begin
                            state_d = ST_REL;
                        end else begin
                            state_d = ST_WAIT;
                            cnt_d   = dec_jmp ? JMP_RELOAD : LD_RELOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    stall_c = 1'b1;
                    flush_c = is_jmp_q;
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_REL;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_HALT: begin
                    stall_c = 1'b1;
                    if (bus.resume) begin
                        state_d = ST_REL;
                    end
                end
                // ins_pm still shows the held instruction here, so skip decode.
                ST_REL: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            is_jmp_q   <= 1'b0;
            stall_pm_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_jmp_q   <= is_jmp_d;
            stall_pm_q <= stall_c;
            halted_q   <= (state_d == ST_HALT);
        end
    end

    stall_perf_counter #(
        .W (PCW)
    ) u_perf (
        .clk     (clk),
        .clr_i   (reset),
        .inc_i   (stall_c),
        .count_o (bus.stall_cycles)
    );

    assign bus.stall     = stall_c;
    assign bus.flush     = flush_c;
    assign bus.stall_pm  = stall_pm_q;
    assign bus.halted    = halted_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (default and LD/JMP=3, PCW=4)
// driven identically and checked cycle by cycle against a stall-budget model.
module tb_hazard_stall_ctrl;
    import pipeline_pkg::*;

    localparam logic [19:0] I_NOP  = 20'h00000;
    localparam logic [19:0] I_LOAD = 20'hA0000;
    localparam logic [19:0] I_JMP  = 20'hE0000;
    localparam logic [19:0] I_HALT = 20'h88000;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_pass;

    hazard_stall_ctrl_if #(.IW(20), .PCW(16)) bus0 ();
    hazard_stall_ctrl_if #(.IW(20), .PCW(4))  bus1 ();

    hazard_stall_ctrl dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    hazard_stall_ctrl #(
        .LD_STALL  (3),
        .JMP_STALL (3),
        .PCW       (4)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog cycle=%0d got timeout required finish", cyc);
        $fatal(1, "watchdog");
    end

    // reference model: remaining stall budget, halt flag, one release cycle
    int   rem_m   [2];
    bit   jmp_m   [2];
    bit   halt_m  [2];
    bit   rel_m   [2];
    bit   spm_m   [2];
    bit   known_m [2];
    int   sc_m    [2];
    int   n_ld    [2] = '{1, 3};
    int   n_jmp   [2] = '{2, 3};
    int   sc_max  [2] = '{65535, 15};

    logic [19:0] exp_q0[$];
    logic [19:0] exp_q1[$];

    function automatic void model_cycle(input int i, input logic rst, input logic [19:0] ins,
                                        input logic ext, input logic res);
        logic st, fl, is_halt, is_jump, is_load;
        logic [19:0] exp_w;
        is_halt = (ins[19:15] == 5'b10001);
        is_jump = (ins[19:17] == 3'b111);
        is_load = (ins[19:15] == 5'b10100);
        st = 1'b0;
        fl = 1'b0;
        if (!rst) begin
            if (ext) st = 1'b1;
            else if (halt_m[i]) st = 1'b1;
            else if (rem_m[i] > 0) begin st = 1'b1; fl = jmp_m[i]; end
            else if (rel_m[i]) st = 1'b0;
            else if (is_halt || is_jump || is_load) begin
                st = 1'b1;
                fl = is_jump && !is_halt;
            end
        end
        exp_w = {st, fl, spm_m[i], halt_m[i], 16'(sc_m[i])};
        if (known_m[i]) begin
            if (i == 0) exp_q0.push_back(exp_w);
            else        exp_q1.push_back(exp_w);
        end
        if (rst) begin
            rem_m[i] = 0; jmp_m[i] = 1'b0; halt_m[i] = 1'b0; rel_m[i] = 1'b0;
            spm_m[i] = 1'b0; sc_m[i] = 0; known_m[i] = 1'b1;
        end else begin
            if (!ext) begin
                if (halt_m[i]) begin
                    if (res) begin halt_m[i] = 1'b0; rel_m[i] = 1'b1; end
                end else if (rem_m[i] > 0) begin
                    rem_m[i]--;
                    if (rem_m[i] == 0) rel_m[i] = 1'b1;
                end else if (rel_m[i]) begin
                    rel_m[i] = 1'b0;
                end else if (is_halt) begin
                    halt_m[i] = 1'b1;
                end else if (is_jump || is_load) begin
                    jmp_m[i] = is_jump;
                    rem_m[i] = (is_jump ? n_jmp[i] : n_ld[i]) - 1;
                    if (rem_m[i] == 0) rel_m[i] = 1'b1;
                end
            end
            spm_m[i] = st;
            if (st && sc_m[i] < sc_max[i]) sc_m[i]++;
        end
    endfunction

    // driver
    task automatic step(input logic rst, input logic [19:0] ins, input logic ext, input logic res);
        @(posedge clk);
        #1;
        reset          = rst;
        bus0.ins_pm    = ins;
        bus0.ext_stall = ext;
        bus0.resume    = res;
        bus1.ins_pm    = ins;
        bus1.ext_stall = ext;
        bus1.resume    = res;
        cyc++;
        for (int i = 0; i < 2; i++) model_cycle(i, rst, ins, ext, res);
    endtask

    task automatic hold(input logic [19:0] ins, input int n);
        for (int k = 0; k < n; k++) step(1'b0, ins, 1'b0, 1'b0);
    endtask

    // scoreboard monitor
    task automatic check(input int idx, input logic [19:0] exp_w, input logic [19:0] got_w,
                         input state_e st);
        n_checks++;
        if (got_w === exp_w) begin
            n_pass++;
        end else begin
            $display("FAIL dut%0d_outputs cycle=%0d state=%s got stall,flush,stall_pm,halted=%b cnt=%0d required %b cnt=%0d",
                     idx, cyc, st.name(), got_w[19:16], got_w[15:0], exp_w[19:16], exp_w[15:0]);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q0.size() > 0)
                check(0, exp_q0.pop_front(),
                      {bus0.stall, bus0.flush, bus0.stall_pm, bus0.halted, bus0.stall_cycles},
                      bus0.dbg_state);
            if (exp_q1.size() > 0)
                check(1, exp_q1.pop_front(),
                      {bus1.stall, bus1.flush, bus1.stall_pm, bus1.halted, 12'd0, bus1.stall_cycles},
                      bus1.dbg_state);
        end
    end

    // stimulus
    initial begin
        logic [19:0] ins;
        int          sel;
        cyc = 0; n_checks = 0; n_pass = 0;
        reset = 1'b1;
        bus0.ins_pm = I_NOP; bus0.ext_stall = 1'b0; bus0.resume = 1'b0;
        bus1.ins_pm = I_NOP; bus1.ext_stall = 1'b0; bus1.resume = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rem_m[i] = 0; jmp_m[i] = 0; halt_m[i] = 0; rel_m[i] = 0;
            spm_m[i] = 0; sc_m[i] = 0; known_m[i] = 0;
        end

        for (int k = 0; k < 3; k++) step(1'b1, I_NOP, 1'b0, 1'b0);
        hold(I_NOP, 2);
        hold(I_LOAD, 3);  hold(I_NOP, 4);
        hold(I_JMP, 4);   hold(I_NOP, 4);
        hold(I_LOAD, 1);  hold(I_NOP, 3); hold(I_LOAD, 1); hold(I_NOP, 5);

        hold(I_HALT, 10);
        step(1'b0, I_HALT, 1'b0, 1'b1);
        hold(I_NOP, 1); hold(I_LOAD, 1); hold(I_NOP, 5);

        step(1'b0, I_JMP, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, I_JMP, 1'b1, 1'b0);
        hold(I_JMP, 2); hold(I_NOP, 5);

        hold(I_HALT, 3);
        step(1'b0, I_HALT, 1'b1, 1'b1);
        step(1'b1, I_HALT, 1'b0, 1'b1);
        hold(I_NOP, 3);

        step(1'b1, I_NOP, 1'b0, 1'b0);
        hold(I_HALT, 20);
        step(1'b0, I_HALT, 1'b0, 1'b1);
        hold(I_NOP, 3);

        for (int k = 0; k < 1500; k++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: ins = {5'b10100, 15'($urandom())};
                3, 4:    ins = {3'b111, 17'($urandom())};
                5:       ins = {5'b10001, 15'($urandom())};
                default: ins = 20'($urandom());
            endcase
            step(($urandom_range(0, 99) == 0), ins,
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
        end
        step(1'b0, I_NOP, 1'b0, 1'b1);
        hold(I_NOP, 6);

        for (int k = 0; k < 8 && (exp_q0.size() > 0 || exp_q1.size() > 0); k++) @(negedge clk);
        #1;
        if (exp_q0.size() > 0 || exp_q1.size() > 0) begin
            n_checks++;
            $display("FAIL drain got pending=%0d required 0", exp_q0.size() + exp_q1.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Parametrised pipeline stall controller for the 8-bit pipelined processor. It decodes the instruction word fetched from program memory and generates the fetch stall, a registered stall for the program-memory stage, and a flush for jump bubbles. Load and jump stall lengths are configurable. A halt is held until an explicit resume, an external stall request can freeze the block, and a saturating counter records stall cycles. It sits between program memory and the IF/ID pipeline register, driving PC hold and bubble insertion.

## Interface
- IW, 20: instruction word width
- OPW, 5: opcode field width; the field is ins_pm[IW-1 -: OPW]
- OP_LOAD, 5'b10100: load opcode
- OP_HALT, 5'b10001: halt opcode
- JPW, 3: jump prefix width; the prefix is ins_pm[IW-1 -: JPW]
- JMP_PREFIX, 3'b111: jump-class prefix
- LD_STALL, 1: stall cycles per load; must be ≥1
- JMP_STALL, 2: stall cycles per jump; must be ≥1
- PCW, 16: stall-cycle counter width

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- ins_pm  in  IW  instruction currently fetched
- ext_stall  in  1  external freeze request (e.g. memory wait)
- resume  in  1  leaves halt
- stall  out  1  combinational; holds PC and IF/ID
- stall_pm  out  1  stall registered by one cycle
- flush  out  1  combinational; inserts a bubble during jump stalls
- halted  out  1  registered; high while in HALT
- stall_cycles  out  PCW  saturating count of cycles with stall=1

## Operation
- States: RUN, WAIT, HALT, REL.
- Internal registers:
  - cnt, width clog2(max(LD_STALL,JMP_STALL)+1)
  - is_jmp, 1 bit
- **RUN**: decodes ins_pm. Priority is HALT > JUMP > LOAD.
  - Halt: stall=1, next state HALT.
  - Jump (N=JMP_STALL) or load (N=LD_STALL): stall=1. is_jmp is set to 1 for a jump, 0 for a load. If N==1, next state REL; otherwise next state WAIT with cnt=N-1.
  - Otherwise: stall=0, stay in RUN.
- **WAIT**: stall=1. If cnt==1, next state REL; otherwise cnt decrements.
- **REL**: stall=0 and decode is suppressed, because ins_pm still shows the held instruction. Next state RUN.
- **HALT**: stall=1. If resume=1, next state REL; otherwise stay in HALT.
- flush = stall & jump-related. That is, it is high in the RUN cycle that decodes a jump and in WAIT while is_jmp=1. It is 0 in all other cycles.
- ext_stall=1 overrides every state:
  - stall=1 and flush=0.
  - State and cnt hold, and no decode takes place.
  - In HALT, ext_stall wins over a simultaneous resume.
  - A jump or load present during ext_stall is decoded in the first cycle after ext_stall drops, if the block is in RUN.
- stall_cycles increments on every cycle with stall=1 and reset=0, and saturates at 2^PCW-1.
- Reset values (applied at the clock edge with reset=1):
  - state = RUN
  - cnt = 0
  - is_jmp = 0
  - stall_pm = 0
  - halted = 0
  - stall_cycles = 0
- While reset=1, stall=0 and flush=0.
- Reset in any state, including mid-WAIT or HALT, aborts the operation immediately.

## Timing
- Instruction I (load or jump, N stall cycles) appears at cycle t in RUN:
  - stall=1 for cycles t..t+N-1
  - stall=0 at t+N (REL)
  - the next instruction is decoded at t+N+1
- Defaults reproduce the existing processor behaviour: load gives 1 bubble, jump gives 2.
- Halt at cycle t:
  - stall=1 from t onward
  - halted=1 from t+1
  - resume sampled at cycle r: stall=0 and halted=0 at r+1 (REL), decode at r+2
- stall_pm(t+1) = stall(t).
- An ext_stall of k cycles during WAIT lengthens the stall window by exactly k cycles.

## Structure
- Shared package (pipeline_pkg) holds:
  - state encoding localparams
  - opcode constants OP_LOAD, OP_HALT, JMP_PREFIX
- Sub-module stall_perf_counter holds the PCW-wide saturating counter with inc and synchronous clear.
- Everything else stays in one FSM module.

## Test plan
- Reset, then hold load 20'hA0000 from cycle t:
  - stall: 1 at t, 0 at t+1, REL
  - stall_pm: 1 at t+1
  - flush: 0 throughout
  - stall_cycles = 1
- Hold jump 20'hE0000 (defaults):
  - stall and flush = 1 at t and t+1, 0 at t+2
  - stall_cycles = 2
- LD_STALL=3, load:
  - stall high for exactly t..t+2
  - the next load at t+4 stalls again
- Halt 20'h88000, held for 10 cycles, then resume pulse at t+10:
  - halted = 1 during t+1..t+10
  - stall = 0 at t+11
  - instruction at t+12 is decoded
- Jump, with ext_stall=1 at t+1..t+3:
  - stall high t..t+4
  - flush low during t+1..t+3 and high at t+4
  - REL at t+5
- Assert reset in mid-HALT with resume=1: RUN, halted=0, stall_cycles=0 on the next cycle.
- PCW=4, 20 halt cycles: stall_cycles saturates at 15.
